// File: rtl/usr_serializer_ctrl.sv
// Purpose: sequences a 4-bit universal shift register as a valid/ready parallel-to-serial converter.
// Latency: 2 cycles from word accept to first serial bit (1 LOAD cycle), 5 cycles per word sustained.
// Backpressure: ser_ready low holds register, counter and bit; in_ready only at IDLE or last-bit accept.
//
// Ports:
//   clock, reset              rising-edge clock, async active-low reset (controller only)
//   in_valid/in_ready/in_data word input handshake; in_msb_first and fill_bit sampled with the word
//   usr_mode, usr_din         drive the shift register MODE (00 hold/01 right/10 left/11 load) and DATAIN
//   usr_q                     shift register DATAOUT, used to pick the current serial bit
//   ser_valid/ser_ready       serial output handshake; ser_bit data, ser_last marks the 4th bit
//   busy                      controller is not idle
module usr_serializer_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    input  logic       in_msb_first,
    input  logic       fill_bit,
    output logic       in_ready,
    output logic [1:0] usr_mode,
    output logic [3:0] usr_din,
    input  logic [3:0] usr_q,
    output logic       ser_valid,
    output logic       ser_bit,
    output logic       ser_last,
    input  logic       ser_ready,
    output logic       busy
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic [3:0] word_q;
    logic       dir_q;
    logic       fill_q;
    logic       accept;
    logic [1:0] ser_idx;

    // Word parameters are captured only on a completed input handshake,
    // so in_valid never reaches an output combinationally.
    assign accept  = in_valid & in_ready;

    // Right shift drains bit 0 first, left shift drains bit 3 first.
    assign ser_idx = dir_q ? 2'd3 : 2'd0;

    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= 2'd0;
            word_q <= 4'd0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                word_q <= in_data;
                dir_q  <= in_msb_first;
                fill_q <= fill_bit;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        usr_mode  = MODE_HOLD;
        usr_din   = 4'd0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        ser_last  = 1'b0;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // Register takes the word at the end of this cycle.
                usr_mode  = MODE_LOAD;
                usr_din   = word_q;
                cnt_nxt   = 2'd0;
                state_nxt = ST_SHIFT;
            end

            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = usr_q[ser_idx];
                ser_last  = (cnt == 2'd3);
                // DATAIN[0] is the serial fill into the vacated end.
                usr_din   = {3'b000, fill_q};
                if (ser_ready) begin
                    usr_mode = dir_q ? MODE_LEFT : MODE_RIGHT;
                    cnt_nxt  = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        // Last bit leaves this cycle: take the next word now
                        // so back-to-back words lose no cycle.
                        in_ready  = 1'b1;
                        state_nxt = in_valid ? ST_LOAD : ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usr_serializer_ctrl.sv
// Bench for usr_serializer_ctrl: a behavioural shift register closes the usr_q loop,
// and a word/bit-queue model predicts every output each cycle.
module tb_usr_serializer_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_msb_first;
    logic       fill_bit;
    logic       in_ready;
    logic [1:0] usr_mode;
    logic [3:0] usr_din;
    logic [3:0] usr_q = 4'h0;
    logic       ser_valid;
    logic       ser_bit;
    logic       ser_last;
    logic       ser_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    usr_serializer_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_msb_first (in_msb_first),
        .fill_bit     (fill_bit),
        .in_ready     (in_ready),
        .usr_mode     (usr_mode),
        .usr_din      (usr_din),
        .usr_q        (usr_q),
        .ser_valid    (ser_valid),
        .ser_bit      (ser_bit),
        .ser_last     (ser_last),
        .ser_ready    (ser_ready),
        .busy         (busy)
    );

    // Universal shift register; DATAIN[0] is the serial input for both shift directions.
    always @(posedge clock) begin
        case (usr_mode)
            2'b11:   usr_q <= usr_din;
            2'b01:   usr_q <= {usr_din[0], usr_q[3:1]};
            2'b10:   usr_q <= {usr_q[2:0], usr_din[0]};
            default: usr_q <= usr_q;
        endcase
    end

    // Reference model: a pending-load flag plus a queue of bits still to send.
    bit         m_bits[$];
    bit         m_load = 1'b0;
    logic [3:0] m_word = 4'h0;
    bit         m_dir  = 1'b0;
    bit         m_fill = 1'b0;

    logic       e_in_ready, e_busy, e_ser_valid, e_ser_bit, e_ser_last;
    logic [1:0] e_mode;
    logic [3:0] e_din;

    task automatic model_eval();
        e_ser_valid = !m_load && (m_bits.size() > 0);
        e_busy      = m_load || (m_bits.size() > 0);
        e_in_ready  = !e_busy || (e_ser_valid && m_bits.size() == 1 && ser_ready);
        e_ser_bit   = e_ser_valid ? m_bits[0] : 1'b0;
        e_ser_last  = e_ser_valid && (m_bits.size() == 1);
        if (m_load) begin
            e_mode = 2'b11;
            e_din  = m_word;
        end else if (e_ser_valid) begin
            e_mode = ser_ready ? (m_dir ? 2'b10 : 2'b01) : 2'b00;
            e_din  = {3'b000, m_fill};
        end else begin
            e_mode = 2'b00;
            e_din  = 4'h0;
        end
    endtask

    // Advances the model across the coming rising edge, using the inputs currently driven.
    task automatic model_commit();
        bit acc;
        acc = in_valid && e_in_ready;
        if (m_load) begin
            m_load = 1'b0;
            for (int i = 0; i < 4; i++)
                m_bits.push_back(m_dir ? m_word[3-i] : m_word[i]);
        end else if (e_ser_valid && ser_ready) begin
            void'(m_bits.pop_front());
        end
        if (acc) begin
            m_load = 1'b1;
            m_word = in_data;
            m_dir  = in_msb_first;
            m_fill = fill_bit;
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {in_ready, busy, ser_valid, usr_mode, usr_din,
                ser_valid ? {ser_bit, ser_last} : 2'b00};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {e_in_ready, e_busy, e_ser_valid, e_mode, e_din, e_ser_bit, e_ser_last};
    endfunction

    function automatic logic [15:0] packq(input bit q[$]);
        logic [15:0] v;
        v = 16'h0;
        foreach (q[i]) v = {v[14:0], q[i]};
        return v;
    endfunction

    task automatic drive(input bit v, input logic [3:0] d, input bit msb, input bit f, input bit r);
        in_valid     = v;
        in_data      = d;
        in_msb_first = msb;
        fill_bit     = f;
        ser_ready    = r;
    endtask

    task automatic test_reset();
        bit got[$];
        reset = 1'b0;
        drive(0, 4'h0, 0, 0, 1);
        @(negedge clock);
        checks++;
        if ({in_ready, busy, ser_valid, usr_mode, usr_din, ser_bit, ser_last} !== 11'b100_00_0000_00) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {in_ready, busy, ser_valid, usr_mode, usr_din, ser_bit, ser_last}, 11'b100_00_0000_00);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 4'b1100, 0, 0, 1);
            @(negedge clock);
            model_eval();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_pre cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (ser_valid && ser_ready) got.push_back(ser_bit);
            model_commit();
            @(posedge clock); #1;
        end
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL reset_pre_bits: got %0d bits expected 2", got.size());
        end
        // Asynchronous reset in the middle of the word.
        reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, ser_valid, usr_mode, usr_din, ser_bit, ser_last} !== 11'b100_00_0000_00) begin
            errors++;
            $display("FAIL reset_mid: got %b expected %b",
                     {in_ready, busy, ser_valid, usr_mode, usr_din, ser_bit, ser_last}, 11'b100_00_0000_00);
        end
        m_bits.delete();
        m_load = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        got.delete();
        for (int c = 0; c < 7; c++) begin
            drive(c == 0, 4'b0110, 0, 0, 1);
            @(negedge clock);
            model_eval();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_post cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (ser_valid && ser_ready) got.push_back(ser_bit);
            model_commit();
            @(posedge clock); #1;
        end
        checks++;
        if (got.size() != 4 || packq(got) !== 16'b0110) begin
            errors++;
            $display("FAIL reset_post_stream: got %0d bits %b expected 4 bits 0110", got.size(), packq(got));
        end
    endtask

    task automatic test_lsb_first();
        bit got[$];
        for (int c = 0; c < 7; c++) begin
            drive(c == 0, 4'b1011, 0, 0, 1);
            @(negedge clock);
            model_eval();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL lsb cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (c == 1) begin
                checks++;
                if (usr_mode !== 2'b11 || usr_din !== 4'b1011) begin
                    errors++;
                    $display("FAIL lsb_load: mode %b din %b expected 11 1011", usr_mode, usr_din);
                end
            end
            if (c == 6) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL lsb_busy_drop: busy %b expected 0", busy);
                end
            end
            if (ser_valid && ser_ready) got.push_back(ser_bit);
            model_commit();
            @(posedge clock); #1;
        end
        checks++;
        if (got.size() != 4 || packq(got) !== 16'b1101) begin
            errors++;
            $display("FAIL lsb_stream: got %0d bits %b expected 4 bits 1101", got.size(), packq(got));
        end
    endtask

    task automatic test_msb_first();
        bit got[$];
        for (int c = 0; c < 7; c++) begin
            drive(c == 0, 4'b1011, 1, 1, 1);
            @(negedge clock);
            model_eval();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL msb cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (usr_mode !== 2'b10 || usr_din[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL msb_shift cyc %0d: mode %b din0 %b expected 10 1", c, usr_mode, usr_din[0]);
                end
            end
            if (ser_valid && ser_ready) got.push_back(ser_bit);
            model_commit();
            @(posedge clock); #1;
        end
        checks++;
        if (got.size() != 4 || packq(got) !== 16'b1011) begin
            errors++;
            $display("FAIL msb_stream: got %0d bits %b expected 4 bits 1011", got.size(), packq(got));
        end
    endtask

    task automatic test_back_to_back();
        bit got[$];
        int gaps;
        gaps = 0;
        for (int c = 0; c < 11; c++) begin
            drive(c <= 5, (c == 0) ? 4'h9 : 4'h6, 0, 0, 1);
            @(negedge clock);
            model_eval();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (c == 5) begin
                checks++;
                if (in_ready !== 1'b1 || ser_last !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_accept: in_ready %b ser_last %b expected 1 1", in_ready, ser_last);
                end
            end
            if (c >= 2 && !ser_valid) gaps++;
            if (ser_valid && ser_ready) got.push_back(ser_bit);
            model_commit();
            @(posedge clock); #1;
        end
        checks++;
        if (got.size() != 8 || packq(got) !== 16'h0096 || gaps != 1) begin
            errors++;
            $display("FAIL b2b_stream: got %0d bits %b gaps %0d expected 8 bits 10010110 gaps 1",
                     got.size(), packq(got), gaps);
        end
    endtask

    task automatic test_stall();
        bit got[$];
        for (int c = 0; c < 10; c++) begin
            drive(c == 0, 4'b0101, 0, 0, !(c >= 4 && c <= 6));
            @(negedge clock);
            model_eval();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (usr_mode !== 2'b00 || ser_bit !== 1'b1 || ser_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d: mode %b bit %b valid %b expected 00 1 1",
                             c, usr_mode, ser_bit, ser_valid);
                end
            end
            if (ser_valid && ser_ready) got.push_back(ser_bit);
            model_commit();
            @(posedge clock); #1;
        end
        checks++;
        if (got.size() != 4 || packq(got) !== 16'b1010) begin
            errors++;
            $display("FAIL stall_stream: got %0d bits %b expected 4 bits 1010", got.size(), packq(got));
        end
    endtask

    task automatic test_ignore_valid();
        bit got[$];
        logic [3:0] d;
        for (int c = 0; c < 12; c++) begin
            if (c == 0)
                drive(1, 4'b1110, 1, 0, 1);
            else if (c <= 4)
                drive(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            else if (c == 5)
                drive(1, 4'b0011, 0, 0, 1);
            else
                drive(0, 4'h0, 0, 0, 1);
            @(negedge clock);
            model_eval();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ignore cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_ready cyc %0d: in_ready %b expected 0", c, in_ready);
                end
            end
            if (ser_valid && ser_ready) got.push_back(ser_bit);
            model_commit();
            @(posedge clock); #1;
        end
        d = 4'h0;
        checks++;
        if (got.size() != 8 || packq(got) !== 16'b1110_1100) begin
            errors++;
            $display("FAIL ignore_stream: got %0d bits %b expected 8 bits 11101100", got.size(), packq(got));
        end
    endtask

    task automatic test_random();
        int words;
        words = 0;
        for (int c = 0; c < 600; c++) begin
            if (c < 580)
                drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
            else
                drive(0, 4'h0, 0, 0, 1);
            @(negedge clock);
            model_eval();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (in_valid && e_in_ready) words++;
            model_commit();
            @(posedge clock); #1;
        end
        checks++;
        if (busy !== 1'b0 || words < 20) begin
            errors++;
            $display("FAIL random_drain: busy %b words %0d expected busy 0 and at least 20 words", busy, words);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 4'h0, 0, 0, 0);
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_stall();
        test_ignore_valid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
